portin: RTL and testbench

Serial input port for the router. Deserialises one frame per `frame_n` window from a single-bit `din` line into a destination address and a 32-bit payload, then writes the result into the destination FIFO with a one-cycle `push`. It is the upstream counterpart of the output-port serialiser: same bit order (LSB first), same active-low `frame_n`/`valid_n` framing. It also reports malformed or undeliverable frames.

---
 rtl/router_pkg.sv | 27 ++
 rtl/portin_sipo.sv | 39 +++
 rtl/portin.sv | 221 ++++++++++++++++++++++
 tb/tb_portin.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: width defaults, err codes, portin state encoding.
// Parity helper used by portin when PORTIN_PARITY_EN is defined.
package router_pkg;

  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_PAYLOAD_W = 32;

  localparam logic [2:0] ERR_NONE   = 3'b000;
  localparam logic [2:0] ERR_SHORT  = 3'b001;
  localparam logic [2:0] ERR_LONG   = 3'b010;
  localparam logic [2:0] ERR_FULL   = 3'b011;
  localparam logic [2:0] ERR_PARITY = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_PAD  = 3'd2,
    S_DATA = 3'd3,
    S_DROP = 3'd4
  } state_e;

  // Even-parity bit over a payload word.
  function automatic logic even_parity(input logic [DEF_PAYLOAD_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/portin_sipo.sv
// sipo_shift: indexed serial-in/parallel-out register; clr zeroes the word,
// load writes bit_in at idx (clr and load together give a fresh word).
module sipo_shift #(
  parameter int W     = 8,
  parameter int IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [IDX_W-1:0] idx,
  input  logic             bit_in,
  output logic [W-1:0]     q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic [W-1:0] base_s;
  logic [W-1:0] onehot_s;

  // Next word: optional clear, then overwrite the selected bit.
  always_comb begin
    base_s   = clr ? {W{1'b0}} : data_q;
    onehot_s = W'(load) << idx;
    data_d   = (base_s & ~onehot_s) | (bit_in ? onehot_s : {W{1'b0}});
  end

  // Word register.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_q <= {W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/portin.sv
// portin: serial router input port, frame deserialiser with error reporting.
// Optional feature macro: PORTIN_PARITY_EN (33rd data bit = even parity).
module portin
  import router_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PAYLOAD_W = DEF_PAYLOAD_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_n,
  input  logic                 valid_n,
  input  logic                 din,
  input  logic                 full,
  output logic                 push,
  output logic [ADDR_W-1:0]    addr,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [2:0]           err,
  output logic                 busy
);

  localparam int AIDX_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;
  localparam int PIDX_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_W - 1);
  localparam logic [5:0] PL_BITS   = 6'(PAYLOAD_W);
`ifdef PORTIN_PARITY_EN
  localparam logic [5:0] FRAME_BITS = PL_BITS + 6'd1;
`else
  localparam logic [5:0] FRAME_BITS = PL_BITS;
`endif

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        push_q, push_d;
  logic [2:0]  err_q, err_d;
  logic        busy_q;
  logic        a_clr_s, a_load_s, p_clr_s, p_load_s;
  logic [AIDX_W-1:0] a_idx_s;
  logic [PIDX_W-1:0] p_idx_s;
`ifdef PORTIN_PARITY_EN
  logic        par_q, par_d;
`endif

  sipo_shift #(.W(ADDR_W)) u_addr_sipo (
    .clock  (clock),
    .reset  (reset),
    .clr    (a_clr_s),
    .load   (a_load_s),
    .idx    (a_idx_s),
    .bit_in (din),
    .q      (addr)
  );

  sipo_shift #(.W(PAYLOAD_W)) u_payload_sipo (
    .clock  (clock),
    .reset  (reset),
    .clr    (p_clr_s),
    .load   (p_load_s),
    .idx    (p_idx_s),
    .bit_in (din),
    .q      (payload)
  );

  // Frame FSM: next state, bit steering and end-of-frame verdict.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    push_d   = 1'b0;
    err_d    = ERR_NONE;
    a_clr_s  = 1'b0;
    a_load_s = 1'b0;
    a_idx_s  = cnt_q[AIDX_W-1:0];
    p_clr_s  = 1'b0;
    p_load_s = 1'b0;
    p_idx_s  = cnt_q[PIDX_W-1:0];
`ifdef PORTIN_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!frame_n) begin
          if (valid_n) begin
            a_clr_s  = 1'b1;
            p_clr_s  = 1'b1;
            a_load_s = 1'b1;
            a_idx_s  = {AIDX_W{1'b0}};
            if (ADDR_W == 1) begin
              state_d = S_PAD;
              cnt_d   = 6'd0;
            end else begin
              state_d = S_ADDR;
              cnt_d   = 6'd1;
            end
          end else begin
            err_d   = ERR_SHORT;
            state_d = S_DROP;
          end
        end else begin
          cnt_d = 6'd0;
        end
      end
      S_ADDR: begin
        if (frame_n) begin
          err_d   = ERR_SHORT;
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else if (!valid_n) begin
          err_d   = ERR_SHORT;
          state_d = S_DROP;
          cnt_d   = 6'd0;
        end else begin
          a_load_s = 1'b1;
          if (cnt_q == ADDR_LAST) begin
            state_d = S_PAD;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_PAD: begin
        if (frame_n) begin
          err_d   = ERR_SHORT;
          state_d = S_IDLE;
        end else if (!valid_n) begin
          p_load_s = 1'b1;
          p_idx_s  = {PIDX_W{1'b0}};
          cnt_d    = 6'd1;
          state_d  = S_DATA;
        end else begin
          state_d = S_PAD;
        end
      end
      S_DATA: begin
        if (frame_n) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
          if (cnt_q != FRAME_BITS) begin
            err_d = ERR_SHORT;
          end else begin
`ifdef PORTIN_PARITY_EN
            // Parity outranks FULL: a corrupt word is never worth reporting as blocked.
            if (par_q != even_parity(payload)) begin
              err_d = ERR_PARITY;
            end else if (full) begin
              err_d = ERR_FULL;
            end else begin
              push_d = 1'b1;
            end
`else
            if (full) begin
              err_d = ERR_FULL;
            end else begin
              push_d = 1'b1;
            end
`endif
          end
        end else if (!valid_n) begin
          if (cnt_q == FRAME_BITS) begin
            err_d   = ERR_LONG;
            state_d = S_DROP;
            cnt_d   = 6'd0;
          end else begin
`ifdef PORTIN_PARITY_EN
            if (cnt_q < PL_BITS) begin
              p_load_s = 1'b1;
            end else begin
              par_d = din;
            end
`else
            p_load_s = 1'b1;
`endif
            cnt_d = cnt_q + 6'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DROP: begin
        if (frame_n) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // State, counter and registered output strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      push_q  <= 1'b0;
      err_q   <= ERR_NONE;
      busy_q  <= 1'b0;
`ifdef PORTIN_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
`ifdef PORTIN_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign push = push_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_portin.sv
// Self-checking bench for portin: directed vector table, hand-written reset
// sequence, and randomized frames checked against a frame-level outcome model.
module tb_portin;

  localparam int AW = 4;
  localparam int PW = 32;
`ifdef PORTIN_PARITY_EN
  localparam int FB = 33;
`else
  localparam int FB = 32;
`endif
  localparam logic [2:0] E_NONE   = 3'b000;
  localparam logic [2:0] E_SHORT  = 3'b001;
  localparam logic [2:0] E_LONG   = 3'b010;
  localparam logic [2:0] E_FULL   = 3'b011;
  localparam logic [2:0] E_PARITY = 3'b100;

  typedef struct {
    bit          is_push;
    logic [3:0]  a;
    logic [31:0] p;
    logic [2:0]  e;
  } ev_t;

  typedef struct {
    logic [3:0]  a;
    logic [31:0] p;
    int          naddr;
    int          npad;
    int          nbub;
    int          dlt;
    bit          bad;
    bit          fl;
    bit          flush;
    bit          xpush;
    logic [2:0]  xerr;
  } vec_t;

  logic          clock;
  logic          reset;
  logic          frame_n;
  logic          valid_n;
  logic          din;
  logic          full;
  logic          push;
  logic [AW-1:0] addr;
  logic [PW-1:0] payload;
  logic [2:0]    err;
  logic          busy;

  int   n_vec = 0;
  int   n_bad = 0;
  ev_t  obs_q[$];
  ev_t  exp_q[$];
  vec_t tbl[$];

  portin dut (
    .clock   (clock),
    .reset   (reset),
    .frame_n (frame_n),
    .valid_n (valid_n),
    .din     (din),
    .full    (full),
    .push    (push),
    .addr    (addr),
    .payload (payload),
    .err     (err),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Record every output event; push and err must never coincide.
  always @(negedge clock) begin
    if (!reset && (push || err != 3'b000)) begin
      n_vec++;
      if (push && err != 3'b000) begin
        n_bad++;
        $display("FAIL push_err_exclusive: got push=1 err=%b, required err=000", err);
      end
      if (push) obs_q.push_back(ev_t'{1'b1, addr, payload, E_NONE});
      else      obs_q.push_back(ev_t'{1'b0, 4'h0, 32'h0, err});
    end
  end

  task automatic drive(input logic fn, input logic vn, input logic d);
    frame_n = fn;
    valid_n = vn;
    din     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // Outcome of one frame from its shape alone.
  function automatic ev_t model(input int naddr, input int ndata, input bit bad,
                                input bit fl, input logic [3:0] a, input logic [31:0] p);
    ev_t ev;
    ev = '{1'b0, 4'h0, 32'h0, E_NONE};
    if (naddr < AW || ndata < FB) ev.e = E_SHORT;
    else if (ndata > FB)          ev.e = E_LONG;
`ifdef PORTIN_PARITY_EN
    else if (bad)                 ev.e = E_PARITY;
`endif
    else if (fl)                  ev.e = E_FULL;
    else begin
      ev.is_push = 1'b1;
      ev.a       = a;
      ev.p       = p;
    end
    return ev;
  endfunction

  task automatic send_frame(input logic [3:0] a, input logic [31:0] p, input int naddr,
                            input int npad, input int nbub, input int ndata,
                            input bit bad, input bit fl, input ev_t xev);
    logic b;
    exp_q.push_back(xev);
    for (int i = 0; i < naddr; i++) begin
      full = 1'($urandom);
      drive(1'b0, 1'b1, a[i]);
    end
    for (int i = 0; i < npad; i++) drive(1'b0, 1'b1, 1'($urandom));
    for (int j = 0; j < ndata; j++) begin
      if (j < 32)       b = p[j];
      else if (j == 32) b = (^p) ^ bad;
      else              b = 1'($urandom);
      full = 1'($urandom);
      drive(1'b0, 1'b0, b);
      if (j >= 1 && j <= nbub) drive(1'b0, 1'b1, 1'($urandom));
    end
    full = fl;
    drive(1'b1, 1'b1, 1'b0);
    full = 1'b0;
  endtask

  task automatic flush(input string tag);
    int n;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s event_count: got %0d, required %0d", tag, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_vec++;
      if (obs_q[i].is_push != exp_q[i].is_push || obs_q[i].a !== exp_q[i].a ||
          obs_q[i].p !== exp_q[i].p || obs_q[i].e !== exp_q[i].e) begin
        n_bad++;
        $display("FAIL %s event%0d: got push=%0b addr=%h payload=%h err=%b, required push=%0b addr=%h payload=%h err=%b",
                 tag, i, obs_q[i].is_push, obs_q[i].a, obs_q[i].p, obs_q[i].e,
                 exp_q[i].is_push, exp_q[i].a, exp_q[i].p, exp_q[i].e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  ev_t         xev;
  int          naddr, npad, nbub, ndata, r;
  bit          bad, fl;
  logic [3:0]  ra;
  logic [31:0] rp;

  initial begin
    reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; din = 1'b0; full = 1'b0;
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    check("rst_push", 32'(push), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_addr", 32'(addr), 32'h0);
    check("rst_payload", payload, 32'h0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0);

    tbl.push_back(vec_t'{4'h5, 32'hDEADBEEF, 4, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE});
    tbl.push_back(vec_t'{4'h5, 32'hDEADBEEF, 4, 3, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1, E_NONE});
    tbl.push_back(vec_t'{4'hA, 32'h00000001, 4, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE});
    tbl.push_back(vec_t'{4'h3, 32'h12345678, 4, 0, 0, -12, 1'b0, 1'b0, 1'b1, 1'b0, E_SHORT});
    tbl.push_back(vec_t'{4'h7, 32'hCAFEF00D, 4, 0, 0, 1, 1'b0, 1'b0, 1'b1, 1'b0, E_LONG});
    tbl.push_back(vec_t'{4'h9, 32'h0F0F0F0F, 4, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, E_FULL});
    tbl.push_back(vec_t'{4'h9, 32'h0F0F0F0F, 4, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE});
    tbl.push_back(vec_t'{4'hC, 32'h00000000, 4, 2, 0, -FB, 1'b0, 1'b0, 1'b1, 1'b0, E_SHORT});
    tbl.push_back(vec_t'{4'h6, 32'hFFFF0000, 2, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, E_SHORT});
    tbl.push_back(vec_t'{4'hE, 32'hAAAA5555, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, E_SHORT});
    tbl.push_back(vec_t'{4'hF, 32'hFFFFFFFF, 4, 1, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE});
    tbl.push_back(vec_t'{4'h1, 32'h00000003, 4, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, E_NONE});
`ifdef PORTIN_PARITY_EN
    tbl.push_back(vec_t'{4'h1, 32'h00000003, 4, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, E_PARITY});
    tbl.push_back(vec_t'{4'h2, 32'h00000003, 4, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, E_PARITY});
    tbl.push_back(vec_t'{4'h2, 32'h80000001, 4, 0, 0, 2, 1'b0, 1'b0, 1'b1, 1'b0, E_LONG});
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].xpush) xev = '{1'b1, tbl[i].a, tbl[i].p, E_NONE};
      else              xev = '{1'b0, 4'h0, 32'h0, tbl[i].xerr};
      send_frame(tbl[i].a, tbl[i].p, tbl[i].naddr, tbl[i].npad, tbl[i].nbub,
                 FB + tbl[i].dlt, tbl[i].bad, tbl[i].fl, xev);
      if (tbl[i].flush) flush($sformatf("vec%0d", i));
      if (i == 0) begin
        check("addr_hold", 32'(addr), 32'h5);
        check("payload_hold", payload, 32'hDEADBEEF);
      end
    end

    // Reset pulse at data bit 10: remainder of the frame is seen as SHORT.
    rp = 32'h13579BDF;
    exp_q.push_back(ev_t'{1'b0, 4'h0, 32'h0, E_SHORT});
    for (int i = 0; i < AW; i++) drive(1'b0, 1'b1, i[0]);
    for (int j = 0; j < 10; j++) drive(1'b0, 1'b0, rp[j]);
    check("busy_mid_frame", 32'(busy), 32'h1);
    reset = 1'b1;
    drive(1'b0, 1'b0, rp[10]);
    reset = 1'b0;
    check("mid_rst_push", 32'(push), 32'h0);
    check("mid_rst_err", 32'(err), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_addr", 32'(addr), 32'h0);
    check("mid_rst_payload", payload, 32'h0);
    for (int j = 11; j < 32; j++) drive(1'b0, 1'b0, rp[j]);
    drive(1'b1, 1'b1, 1'b0);
    flush("mid_reset");
    send_frame(4'h5, 32'hDEADBEEF, AW, 0, 0, FB, 1'b0, 1'b0,
               model(AW, FB, 1'b0, 1'b0, 4'h5, 32'hDEADBEEF));
    flush("post_reset");

    for (int k = 0; k < 60; k++) begin
      ra    = 4'($urandom);
      rp    = $urandom;
      naddr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, AW - 1) : AW;
      npad  = (naddr < AW) ? 0 : $urandom_range(0, 3);
      nbub  = $urandom_range(0, 4);
      r     = $urandom_range(0, 9);
      if (r == 6)      ndata = FB - $urandom_range(1, FB);
      else if (r == 7) ndata = FB + 1;
      else if (r == 8) ndata = FB + 2;
      else             ndata = FB;
      bad   = ($urandom_range(0, 3) == 0);
      fl    = ($urandom_range(0, 3) == 0);
      send_frame(ra, rp, naddr, npad, nbub, ndata, bad, fl,
                 model(naddr, ndata, bad, fl, ra, rp));
      if (k % 4 == 3) flush($sformatf("rand%0d", k));
    end
    flush("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
